// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline registers: default widths and the
// occupancy state used by the skid-buffered stages.
package pipe_pkg;
    localparam int PIPE_RD_W   = 2;
    localparam int PIPE_DATA_W = 8;
    localparam int PIPE_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_reg_mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid buffer, synchronous flush
// and a saturating count of WB-idle cycles.
module pipe_reg_mem_wb_skid
    import pipe_pkg::*;
#(
    parameter int RD_W   = PIPE_RD_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_mem,
    output logic              out_wen,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [1:0]        dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is a function of state only, so WB back-pressure never
    // reaches MEM combinationally, and out_* hold while out_valid & !out_ready.
    skid_state_e       state_q, state_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
    logic [DATA_W-1:0] main_mem_q, main_mem_d, skid_mem_q, skid_mem_d;
    logic              main_wen_q, main_wen_d, skid_wen_q, skid_wen_d;
    logic              in_fire, out_fire;

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        main_rd_d  = main_rd_q;
        main_mem_d = main_mem_q;
        main_wen_d = main_wen_q;
        skid_rd_d  = skid_rd_q;
        skid_mem_d = skid_mem_q;
        skid_wen_d = skid_wen_q;
        if (flush) begin
            // An out_fire this cycle is still consumed; the incoming entry is dropped.
            state_d    = ST_EMPTY;
            main_rd_d  = '0;
            main_mem_d = '0;
            main_wen_d = 1'b0;
            skid_rd_d  = '0;
            skid_mem_d = '0;
            skid_wen_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_rd_d  = in_rd;
                        main_mem_d = in_mem;
                        main_wen_d = in_wen;
                        state_d    = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_rd_d  = in_rd;
                        main_mem_d = in_mem;
                        main_wen_d = in_wen;
                    end else if (in_fire) begin
                        skid_rd_d  = in_rd;
                        skid_mem_d = in_mem;
                        skid_wen_d = in_wen;
                        state_d    = ST_SKID;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        main_rd_d  = skid_rd_q;
                        main_mem_d = skid_mem_q;
                        main_wen_d = skid_wen_q;
                        state_d    = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_rd_q  <= '0;
            main_mem_q <= '0;
            main_wen_q <= 1'b0;
            skid_rd_q  <= '0;
            skid_mem_q <= '0;
            skid_wen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_rd_q  <= main_rd_d;
            main_mem_q <= main_mem_d;
            main_wen_q <= main_wen_d;
            skid_rd_q  <= skid_rd_d;
            skid_mem_q <= skid_mem_d;
            skid_wen_q <= skid_wen_d;
        end
    end

    assign out_rd    = main_rd_q;
    assign out_mem   = main_mem_q;
    assign out_wen   = main_wen_q & out_valid;
    assign dbg_state = state_q;

    // WB sat idle while willing to accept: a pipeline bubble.
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid & out_ready),
        .count (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_reg_mem_wb_skid.sv
// Bench for pipe_reg_mem_wb_skid: vector table, queue-based scoreboard and
// hand-written reset / saturation sequences.
module tb_pipe_reg_mem_wb_skid;
    localparam int RD_W   = 2;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
    localparam int E_W    = RD_W + DATA_W + 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_mem;
    logic              in_wen;
    logic              out_valid;
    logic              out_ready;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_mem;
    logic              out_wen;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [1:0]        dbg_state;

    pipe_reg_mem_wb_skid #(.RD_W(RD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_mem     (in_mem),
        .in_wen     (in_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_mem    (out_mem),
        .out_wen    (out_wen),
        .bubble_cnt (bubble_cnt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              iv;
        logic              ordy;
        logic              fl;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] mem;
        logic              wen;
        logic              e_ir;
        logic              e_ov;
        logic              e_cm;
        logic [DATA_W-1:0] e_mem;
        logic              e_wen;
    } vec_t;

    vec_t           tbl[20];
    logic [E_W-1:0] exp_q[$];
    int             bub;
    int             checks;
    int             errors;

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [RD_W-1:0] rd,
                                logic [DATA_W-1:0] mem, logic wen, logic e_ir, logic e_ov,
                                logic e_cm, logic [DATA_W-1:0] e_mem, logic e_wen);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.rd = rd; v.mem = mem; v.wen = wen;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_cm = e_cm; v.e_mem = e_mem; v.e_wen = e_wen;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] mem,
                         input logic wen, input logic ordy, input logic fl);
        in_valid  = iv;
        in_rd     = rd;
        in_mem    = mem;
        in_wen    = wen;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Check outputs against the scoreboard, advance the model, then one clock.
    task automatic tick();
        logic [E_W-1:0] head;
        int             sz;
        sz = exp_q.size();
        chk("out_valid", out_valid, sz != 0);
        chk("in_ready", in_ready, sz < 2);
        chk("dbg_state", dbg_state, sz);
        chk("bubble_cnt", bubble_cnt, bub);
        if (sz != 0) begin
            head = exp_q[0];
            chk("out_rd", out_rd, head[E_W-1 -: RD_W]);
            chk("out_mem", out_mem, head[DATA_W:1]);
            chk("out_wen", out_wen, head[0]);
        end else begin
            chk("out_wen_idle", out_wen, 0);
        end
        if (sz == 0 && out_ready && bub < 7) bub++;
        if (sz != 0 && out_ready) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_valid && sz < 2) exp_q.push_back({in_rd, in_mem, in_wen});
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bub    = 0;
        reset  = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        tbl[0]  = mk(1, 1, 0, 2'd1, 8'h11, 1, 1, 1, 1, 8'h11, 1);
        tbl[1]  = mk(1, 1, 0, 2'd2, 8'h22, 0, 1, 1, 1, 8'h22, 0);
        tbl[2]  = mk(1, 1, 0, 2'd3, 8'h33, 1, 1, 1, 1, 8'h33, 1);
        tbl[3]  = mk(0, 1, 0, 2'd0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        tbl[4]  = mk(1, 0, 0, 2'd1, 8'hA1, 1, 1, 1, 1, 8'hA1, 1);
        tbl[5]  = mk(1, 0, 0, 2'd2, 8'hA2, 0, 0, 1, 1, 8'hA1, 1);
        tbl[6]  = mk(1, 0, 0, 2'd3, 8'hA3, 1, 0, 1, 1, 8'hA1, 1);
        tbl[7]  = mk(1, 1, 0, 2'd3, 8'hA3, 1, 1, 1, 1, 8'hA2, 0);
        tbl[8]  = mk(1, 1, 0, 2'd3, 8'hA3, 1, 1, 1, 1, 8'hA3, 1);
        tbl[9]  = mk(0, 1, 0, 2'd0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        tbl[10] = mk(1, 0, 0, 2'd1, 8'hB1, 1, 1, 1, 1, 8'hB1, 1);
        tbl[11] = mk(1, 0, 0, 2'd2, 8'hB2, 1, 0, 1, 1, 8'hB1, 1);
        tbl[12] = mk(1, 0, 1, 2'd3, 8'hB3, 1, 1, 0, 1, 8'h00, 0);
        tbl[13] = mk(0, 0, 0, 2'd0, 8'h00, 0, 1, 0, 1, 8'h00, 0);
        tbl[14] = mk(1, 0, 0, 2'd2, 8'hC1, 1, 1, 1, 1, 8'hC1, 1);
        tbl[15] = mk(0, 1, 0, 2'd0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        tbl[16] = mk(1, 1, 0, 2'd1, 8'hD1, 0, 1, 1, 1, 8'hD1, 0);
        tbl[17] = mk(0, 1, 0, 2'd0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        tbl[18] = mk(1, 0, 0, 2'd2, 8'hE1, 1, 1, 1, 1, 8'hE1, 1);
        tbl[19] = mk(1, 1, 1, 2'd3, 8'hE2, 1, 1, 0, 1, 8'h00, 0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].iv, tbl[i].rd, tbl[i].mem, tbl[i].wen, tbl[i].ordy, tbl[i].fl);
            tick();
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d_out_wen", i), out_wen, tbl[i].e_wen);
            if (tbl[i].e_cm) chk($sformatf("vec%0d_out_mem", i), out_mem, tbl[i].e_mem);
        end
        chk("queue_drained", exp_q.size(), 0);

        // Reset arriving asynchronously while both registers are occupied.
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'd2, 8'h5B, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_state", dbg_state, 2);
        chk("pre_reset_bubble_nonzero", bubble_cnt != 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_mem", out_mem, 0);
        chk("rst_out_wen", out_wen, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_state", dbg_state, 0);
        exp_q.delete();
        bub = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Bubble counter: stalled idle cycles do not count, ready idle cycles saturate.
        for (int i = 0; i < 3; i++) tick();
        chk("bubble_no_ready", bubble_cnt, 0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("bubble_saturated", bubble_cnt, 7);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick();
        chk("bubble_held", bubble_cnt, 7);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), RD_W'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
